// File: rtl/reaction_game_ctrl_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_game_ctrl_pkg;

  // Sequencer states; codes 5-7 are illegal and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GO    = 3'd2,
    SHOW  = 3'd3,
    FAULT = 3'd4
  } state_e;

  // Seven-segment source select.
  typedef enum logic [1:0] {
    DISP_LIVE   = 2'd0,
    DISP_RESULT = 2'd1,
    DISP_HI     = 2'd2,
    DISP_FAULT  = 2'd3
  } disp_e;

  // 4-digit display ceiling and power-on high score.
  localparam int unsigned RG_MAX_TIME     = 9999;
  localparam int unsigned RG_HISCORE_INIT = 9999;

endpackage

// File: rtl/reaction_game_ctrl_hiscore.sv
// Best-time register: keeps the lowest candidate offered on an update strobe.
module hiscore_keeper #(
  parameter int unsigned W    = 14,
  parameter int unsigned INIT = 9999
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         upd_i,
  input  logic [W-1:0] cand_i,
  output logic         better_o,
  output logic [W-1:0] hi_o
);

  logic [W-1:0] hi_q;

  assign better_o = (cand_i < hi_q);
  assign hi_o     = hi_q;

  // Replace the stored best only when the offered time is strictly lower.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= W'(INIT);
    end else if (upd_i && better_o) begin
      hi_q <= cand_i;
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: random arm delay, LED go signal, timed response,
// result hold and high-score tracking, all in one synchronous FSM.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int unsigned DELAY_W      = 11,
  parameter int unsigned TIME_W       = 14,
  parameter int unsigned MIN_DELAY    = 500,
  parameter int unsigned MAX_TIME     = RG_MAX_TIME,
  parameter int unsigned SHOW_MS      = 2000,
  parameter int unsigned HISCORE_INIT = RG_HISCORE_INIT
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset,
  input  logic               start_pulse,
  input  logic               stop_pulse,
  input  logic               ms_tick,
  input  logic [DELAY_W-1:0] rand_delay,
  input  logic               show_hi,
  output logic               lfsr_en,
  output logic               bcd_clr,
  output logic               bcd_en,
  output logic               led_on,
  output logic [1:0]         disp_sel,
  output logic [TIME_W-1:0]  result_ms,
  output logic [TIME_W-1:0]  hiscore_ms,
  output logic               new_record,
  output logic               timeout,
  output logic [2:0]         state_dbg
);

  state_e              state_q;
  logic [TIME_W-1:0]   ms_cnt_q;
  logic [DELAY_W:0]    target_q;
  logic                lfsr_en_q;
  logic                bcd_clr_q;
  logic                bcd_en_q;
  logic                led_on_q;
  disp_e               disp_q;
  logic [TIME_W-1:0]   result_q;
  logic                new_record_q;
  logic                timeout_q;

  logic [DELAY_W:0]    target_d;
  logic [TIME_W-1:0]   target_m1;
  logic                arm_done;
  logic                go_timeout;
  logic                hold_done;
  logic                hs_upd;
  logic                hs_better;

  // One extra bit on the target so MIN_DELAY + max LFSR value cannot wrap.
  assign target_d   = (DELAY_W+1)'(MIN_DELAY) + {1'b0, rand_delay};
  assign target_m1  = TIME_W'(target_q) - 1'b1;
  assign arm_done   = ms_tick && (ms_cnt_q == target_m1);
  assign go_timeout = ms_tick && (ms_cnt_q == TIME_W'(MAX_TIME - 1));
  assign hold_done  = ms_tick && (ms_cnt_q == TIME_W'(SHOW_MS - 1));
  assign hs_upd     = (state_q == GO) && stop_pulse;

  hiscore_keeper #(
    .W    (TIME_W),
    .INIT (HISCORE_INIT)
  ) u_hiscore (
    .clk_i    (MAX10_CLK1_50),
    .rst_i    (reset),
    .upd_i    (hs_upd),
    .cand_i   (ms_cnt_q),
    .better_o (hs_better),
    .hi_o     (hiscore_ms)
  );

  // Main sequencer with all outputs registered; strobes default low each cycle.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q      <= IDLE;
      ms_cnt_q     <= '0;
      target_q     <= '0;
      lfsr_en_q    <= 1'b1;
      bcd_clr_q    <= 1'b0;
      bcd_en_q     <= 1'b0;
      led_on_q     <= 1'b0;
      disp_q       <= DISP_LIVE;
      result_q     <= '0;
      new_record_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      bcd_clr_q <= 1'b0;
      bcd_en_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          lfsr_en_q <= 1'b1;
          led_on_q  <= 1'b0;
          disp_q    <= show_hi ? DISP_HI : DISP_RESULT;
          if (start_pulse) begin
            target_q  <= target_d;
            ms_cnt_q  <= '0;
            lfsr_en_q <= 1'b0;
            state_q   <= ARM;
          end
        end
        ARM: begin
          // A false start outranks a delay expiring in the same cycle.
          if (stop_pulse) begin
            ms_cnt_q <= '0;
            disp_q   <= DISP_FAULT;
            state_q  <= FAULT;
          end else if (arm_done) begin
            ms_cnt_q  <= '0;
            led_on_q  <= 1'b1;
            bcd_clr_q <= 1'b1;
            disp_q    <= DISP_LIVE;
            state_q   <= GO;
          end else if (ms_tick) begin
            ms_cnt_q <= ms_cnt_q + 1'b1;
          end
        end
        GO: begin
          // Stop outranks a coincident tick: that tick is neither counted nor shown.
          if (stop_pulse) begin
            result_q     <= ms_cnt_q;
            new_record_q <= hs_better;
            led_on_q     <= 1'b0;
            ms_cnt_q     <= '0;
            disp_q       <= DISP_RESULT;
            state_q      <= SHOW;
          end else if (go_timeout) begin
            bcd_en_q  <= 1'b1;
            result_q  <= TIME_W'(MAX_TIME);
            timeout_q <= 1'b1;
            led_on_q  <= 1'b0;
            ms_cnt_q  <= '0;
            disp_q    <= DISP_RESULT;
            state_q   <= SHOW;
          end else if (ms_tick) begin
            bcd_en_q <= 1'b1;
            ms_cnt_q <= ms_cnt_q + 1'b1;
          end
        end
        SHOW, FAULT: begin
          disp_q   <= (state_q == FAULT) ? DISP_FAULT : DISP_RESULT;
          led_on_q <= 1'b0;
          if (hold_done) begin
            ms_cnt_q     <= '0;
            new_record_q <= 1'b0;
            timeout_q    <= 1'b0;
            lfsr_en_q    <= 1'b1;
            state_q      <= IDLE;
          end else if (ms_tick) begin
            ms_cnt_q <= ms_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lfsr_en    = lfsr_en_q;
  assign bcd_clr    = bcd_clr_q;
  assign bcd_en     = bcd_en_q;
  assign led_on     = led_on_q;
  assign disp_sel   = disp_q;
  assign result_ms  = result_q;
  assign new_record = new_record_q;
  assign timeout    = timeout_q;
  assign state_dbg  = state_q;

endmodule
